// File: rtl/lcd_line_feeder_if.sv
// Byte streams around the LCD line feeder: ASCII beats in, command/data bytes out.
interface lcd_line_feeder_if;
    logic [7:0] in_data;
    logic       in_eol;
    logic       in_eol_only;
    logic       in_valid;
    logic       in_ready;
    logic       out_rs;
    logic [7:0] out_db;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_eol, in_eol_only, in_valid,
        input  in_ready,
        input  out_rs, out_db, out_valid,
        output out_ready
    );

    modport slave (
        input  in_data, in_eol, in_eol_only, in_valid,
        output in_ready,
        output out_rs, out_db, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/lcd_line_feeder.sv
// Buffers one display line of ASCII bytes, then replays it to the LCD driver as
// a set-DDRAM-address command followed by DEPTH space-padded character writes.
//
// state | meaning
// FILL  | accepting input bytes into the line buffer
// CMD   | presenting the LINE_ADDR command byte
// CHAR  | presenting stored characters buf[0..count-1]
// PAD   | presenting spaces until DEPTH characters have gone out
module lcd_line_feeder #(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] LINE_ADDR = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    lcd_line_feeder_if.slave  bus,
    output logic              busy
);
    typedef enum logic [1:0] {FILL, CMD, CHAR, PAD} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [7:0]      SPACE   = 8'h20;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   count, count_nxt;
    logic [ADDR_W:0]   idx, idx_nxt;
    logic              out_valid_q, valid_nxt;
    logic              out_rs_q, rs_nxt;
    logic [7:0]        out_db_q, db_nxt;
    logic              wr_en;
    logic              finish;
    logic [7:0]        char_in;
    logic [7:0]        line_buf [2**ADDR_W];

    // Non-printable bytes would show as garbage glyphs, so store '?' instead.
    assign char_in = (bus.in_data < 8'h20 || bus.in_data > 8'h7E) ? 8'h3F : bus.in_data;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        idx_nxt   = idx;
        valid_nxt = out_valid_q;
        rs_nxt    = out_rs_q;
        db_nxt    = out_db_q;
        wr_en     = 1'b0;
        finish    = 1'b0;
        case (state)
            FILL: begin
                if (bus.in_valid) begin
                    if (!bus.in_eol_only) begin
                        wr_en     = 1'b1;
                        count_nxt = count + 1'b1;
                    end
                    if (bus.in_eol || bus.in_eol_only || count_nxt == DEPTH_C) begin
                        state_nxt = CMD;
                        idx_nxt   = '0;
                        valid_nxt = 1'b1;
                        rs_nxt    = 1'b0;
                        db_nxt    = LINE_ADDR;
                    end
                end
            end
            CMD: begin
                if (bus.out_ready) begin
                    rs_nxt  = 1'b1;
                    idx_nxt = '0;
                    if (count != '0) begin
                        state_nxt = CHAR;
                        db_nxt    = line_buf[0];
                    end else begin
                        state_nxt = PAD;
                        db_nxt    = SPACE;
                    end
                end
            end
            CHAR: begin
                if (bus.out_ready) begin
                    idx_nxt = idx + 1'b1;
                    if (idx_nxt == count) begin
                        if (count < DEPTH_C) begin
                            state_nxt = PAD;
                            db_nxt    = SPACE;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        db_nxt = line_buf[idx_nxt[ADDR_W-1:0]];
                    end
                end
            end
            PAD: begin
                if (bus.out_ready) begin
                    idx_nxt = idx + 1'b1;
                    if (idx_nxt == DEPTH_C) begin
                        finish = 1'b1;
                    end else begin
                        db_nxt = SPACE;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
        if (finish) begin
            state_nxt = FILL;
            count_nxt = '0;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
            rs_nxt    = 1'b0;
            db_nxt    = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            count       <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            out_rs_q    <= 1'b0;
            out_db_q    <= 8'h00;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            idx         <= idx_nxt;
            out_valid_q <= valid_nxt;
            out_rs_q    <= rs_nxt;
            out_db_q    <= db_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            line_buf[count[ADDR_W-1:0]] <= char_in;
        end
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_rs    = out_rs_q;
    assign bus.out_db    = out_db_q;
    assign busy          = (state != FILL);
endmodule

// File: tb/tb_lcd_line_feeder.sv
// Scoreboard bench for lcd_line_feeder: a line-level model turns accepted beats into
// expected 17-byte streams; a monitor checks handshakes and bytes every cycle.
module tb_lcd_line_feeder;
    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    lcd_line_feeder_if bus();

    lcd_line_feeder #(.DEPTH(16), .ADDR_W(4), .LINE_ADDR(8'h80)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         xfers    = 0;
    bit         started  = 1'b0;
    bit         rand_ready = 1'b0;
    logic [8:0] exp_q [$];
    logic [7:0] line_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sanit(input logic [7:0] b);
        return (b < 8'h20 || b > 8'h7E) ? 8'h3F : b;
    endfunction

    // Reference: a line is a list of chars; a flush emits the address then 16 slots.
    task automatic model_accept(input logic [7:0] d, input bit eol, input bit eol_only);
        if (!eol_only) line_q.push_back(sanit(d));
        if (eol || eol_only || line_q.size() == 16) begin
            exp_q.push_back({1'b0, 8'h80});
            for (int i = 0; i < 16; i++)
                exp_q.push_back({1'b1, (i < line_q.size()) ? line_q[i] : 8'h20});
            line_q.delete();
        end
    endtask

    initial begin : monitor
        bit         stall_prev;
        bit         exp_busy;
        logic       rs_prev;
        logic [7:0] db_prev;
        logic [8:0] e;
        stall_prev = 1'b0;
        rs_prev = 1'b0;
        db_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (!started) begin
                if (rst === 1'b1) started = 1'b1;
                continue;
            end
            exp_busy = (exp_q.size() != 0);
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, !exp_busy});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_busy});
            if (stall_prev) begin
                check("hold_rs", {31'd0, bus.out_rs}, {31'd0, rs_prev});
                check("hold_db", {24'd0, bus.out_db}, {24'd0, db_prev});
            end
            if (rst) begin
                exp_q.delete();
                line_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL out_byte: got rs=%0b db=%0h, expected no byte at %0t",
                                 bus.out_rs, bus.out_db, $time);
                    end else begin
                        n_checks--;
                        e = exp_q.pop_front();
                        check("out_byte", {23'd0, bus.out_rs, bus.out_db}, {23'd0, e});
                        xfers++;
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                rs_prev    = bus.out_rs;
                db_prev    = bus.out_db;
                if (bus.in_valid && !exp_busy)
                    model_accept(bus.in_data, bus.in_eol, bus.in_eol_only);
            end
        end
    end

    initial begin : ready_drv
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit eol, input bit eol_only);
        int waited = 0;
        bus.in_data     = d;
        bus.in_eol      = eol;
        bus.in_eol_only = eol_only;
        bus.in_valid    = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            waited++;
            if (waited > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready still %0b, expected 1 within 300 cycles", bus.in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_eol      = 1'b0;
        bus.in_eol_only = 1'b0;
        bus.in_data     = 8'h00;
    endtask

    task automatic send_str(input string s, input bit eol);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], eol && (i == s.len() - 1), 1'b0);
    endtask

    task automatic wait_idle();
        int w = 0;
        repeat (2) @(negedge clk);
        while ((exp_q.size() != 0 || busy !== 1'b0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int base;
        int len;
        int w;
        rst = 1'b1;
        bus.in_data = 8'h00;
        bus.in_eol = 1'b0;
        bus.in_eol_only = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rs", {31'd0, bus.out_rs}, 32'd0);
        check("reset_db", {24'd0, bus.out_db}, 32'd0);
        @(posedge clk);
        #1;

        send_str("HI", 1'b1);
        wait_idle();

        send_str("MASTER1_ABCDEFGH", 1'b0);
        send_byte("Z", 1'b1, 1'b0);
        wait_idle();

        send_byte(8'h0A, 1'b0, 1'b0);
        send_byte(8'h7F, 1'b0, 1'b0);
        send_byte("A", 1'b1, 1'b0);
        wait_idle();

        rand_ready = 1'b1;
        send_str("MASTER", 1'b1);
        wait_idle();
        rand_ready = 1'b0;

        send_byte(8'h00, 1'b0, 1'b1);
        wait_idle();
        send_str("0123456789abcdef", 1'b1);
        wait_idle();

        for (int k = 0; k < 8; k++) begin
            rand_ready = ($urandom_range(0, 1) == 1);
            len = $urandom_range(0, 18);
            if (len == 0) begin
                send_byte(8'h00, 1'b0, 1'b1);
            end else begin
                for (int i = 0; i < len; i++) begin
                    send_byte(8'($urandom_range(0, 255)),
                              (i == len - 1) && ($urandom_range(0, 3) != 0), 1'b0);
                    repeat ($urandom_range(0, 1)) @(posedge clk);
                    #1;
                end
            end
        end
        send_byte(8'h00, 1'b0, 1'b1);
        wait_idle();
        rand_ready = 1'b0;

        base = xfers;
        send_str("ABCDEFG", 1'b1);
        w = 0;
        while (xfers < base + 3 && w < 200) begin
            @(posedge clk);
            w++;
        end
        if (w >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: %0d bytes accepted, expected 3", xfers - base);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_str("OK", 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_line_feeder.md
Name: lcd_line_feeder

Overview:
Upstream stage of the LCD character driver. Collects ASCII bytes from the I2C receive path over a valid/ready input, buffers one 16-character display line, then replays it to the LCD driver as one command/data byte stream.
- Stream per line: a set-DDRAM-address command, then exactly DEPTH character writes, space-padded.
- The LCD driver owns all enable-pulse timing. This block only sequences bytes and never drives rw.

Parameters:
DEPTH, 16, characters per display line (buffer entries); must be ≤ 2**ADDR_W.
ADDR_W, 4, buffer index width.
LINE_ADDR, 8'h80, command byte emitted before each line (HD44780 set-DDRAM, line 1 col 0).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  8  ASCII byte from upstream.
in_eol  input  1  qualifies in_data beat: this byte ends the line.
in_eol_only  input  1  with in_valid: flush now, in_data ignored (no char stored).
in_valid  input  1  upstream beat valid.
in_ready  output  1  block accepts beat this cycle.
out_rs  output  1  0 = command byte, 1 = character byte.
out_db  output  8  byte to LCD driver.
out_valid  output  1  out_rs/out_db valid.
out_ready  input  1  LCD driver accepts byte this cycle.
busy  output  1  high from flush trigger until last byte accepted.

Behaviour:
- One clock, clk. rst synchronous, active-high. rst wins over every other event in the same cycle.
- Reset values: state=FILL, count=0, in_ready=1, out_valid=0, out_rs=0, out_db=8'h00, busy=0. Buffer contents are don't-care.
- Reset mid-line or mid-stream:
  - abandons the line and drops out_valid on the next edge;
  - the driver sees no further bytes from that line.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_rs/out_db are registered and held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on rst.
- Character sanitising on store:
  - bytes < 8'h20 or > 8'h7E are stored as 8'h3F ('?');
  - all other bytes are stored unchanged.
- FSM states: FILL, CMD, CHAR, PAD.
- FILL:
  - in_ready=1.
  - An input transfer with in_eol_only=0 stores the sanitised byte at buf[count] and increments count.
  - Flush trigger, evaluated after the store:
    - in_eol=1, or
    - in_eol_only=1, or
    - count reaches DEPTH (auto-flush).
  - On trigger: next state CMD, in_ready=0 from the next cycle, busy=1, idx=0.
  - A byte with in_eol on the DEPTH-th position triggers exactly one flush.
- CMD:
  - out_valid=1, out_rs=0, out_db=LINE_ADDR.
  - On transfer: go to CHAR if count>0, else PAD.
- CHAR:
  - out_rs=1, out_db=buf[idx].
  - On transfer: idx++. When idx reaches count, go to PAD if count<DEPTH, else finish.
- PAD:
  - out_rs=1, out_db=8'h20.
  - On transfer: idx++. At idx==DEPTH, finish.
- Finish:
  - out_valid=0 and busy=0 the cycle after the last transfer.
  - count=0, state=FILL, in_ready=1 on that same cycle.
- Stream length per flush is always 1+DEPTH bytes, regardless of count.
  - An empty line (in_eol_only with count=0) yields LINE_ADDR plus 16 spaces, which clears the line.
- Back-to-back output: with out_ready held 1, one byte per cycle, no bubbles between CMD/CHAR/PAD.
  - Flush trigger to first out_valid: 1 cycle.
- Input is stalled (in_ready=0) during CMD/CHAR/PAD. There is no overlap between fill and replay.
- count and idx are ADDR_W+1 bits wide so that DEPTH=16 is representable without wrap.

Test Plan:
1. Reset, then send "HI" with in_eol on 'I', out_ready=1 → 0x80(rs0), 0x48, 0x49, then 14×0x20(rs1). busy high for 17 cycles; in_ready=1 again on cycle 18.
2. Send 16 bytes "MASTER1_ABCDEFGH" with no eol → auto-flush after 16th beat; 0x80 then exactly those 16 bytes, no padding. 17th input beat is held off (in_ready=0) until finish.
3. Send 0x0A, 0x7F, 'A' with eol → stored/emitted as 0x3F, 0x3F, 0x41, followed by 13 spaces.
4. Toggle out_ready pseudo-randomly during replay of "MASTER" → out_db/out_rs stable while stalled; emitted sequence exactly 0x80, M,A,S,T,E,R, then 10×0x20; no duplicates or drops.
5. in_eol_only with count=0 → 0x80 then 16×0x20. Then in_eol on the 16th byte → single flush, 17 bytes only.
6. Assert rst in CHAR after 3 bytes accepted → next cycle out_valid=0, busy=0, in_ready=1; a fresh line "OK"+eol then produces a clean 17-byte stream starting with 0x80.
